// File: rtl/router_src_arbiter.sv
// Packet-level round-robin arbiter sharing the single router input among NUM_SRC sources.
// A grant covers one whole packet: header, payload and parity, plus a drain cycle for router busy.
module router_src_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DW      = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_SRC-1:0]    src_pkt_valid,
  input  logic [NUM_SRC*DW-1:0] src_data,
  input  logic                  router_busy,
  output logic [NUM_SRC-1:0]    src_busy,
  output logic [NUM_SRC-1:0]    src_grant,
  output logic                  pkt_valid,
  output logic [DW-1:0]         data_in,
  output logic                  len_err
);

  localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned LW = DW - 2;
  localparam int unsigned CW = DW - 1;
  // Saturation point sits one past the largest legal header+len count.
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << LW) + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]         r_state, w_state_nxt;
  logic [IW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]      r_gidx, w_gidx_nxt;
  logic [NUM_SRC-1:0] r_grant, w_grant_nxt;
  logic [CW-1:0]      r_byte_cnt, w_byte_cnt_nxt;
  logic [LW-1:0]      r_len, w_len_nxt;
  logic               r_len_err, w_len_err_nxt;

  logic               w_found;
  logic [IW-1:0]      w_pick;
  logic [IW-1:0]      w_cand;
  logic               w_sel_valid;
  logic [DW-1:0]      w_sel_data;
  logic               w_accept;

  // First requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      w_cand = IW'((int'(r_rr_ptr) + k) % int'(NUM_SRC));
      if (!w_found && src_pkt_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_valid = src_pkt_valid[r_gidx];
    w_sel_data  = src_data[int'(r_gidx)*DW +: DW];
    src_busy    = '1;
    pkt_valid   = 1'b0;
    data_in     = '0;
    if (r_state == S_XFER) begin
      pkt_valid        = w_sel_valid;
      data_in          = w_sel_data;
      src_busy[r_gidx] = router_busy;
    end
  end

  assign w_accept = (r_state == S_XFER) && w_sel_valid && !router_busy;

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_gidx_nxt     = r_gidx;
    w_grant_nxt    = r_grant;
    w_byte_cnt_nxt = r_byte_cnt;
    w_len_nxt      = r_len;
    w_len_err_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !router_busy) begin
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_gidx_nxt          = w_pick;
          w_state_nxt         = S_XFER;
        end
      end
      S_XFER: begin
        if (w_accept) begin
          if (r_byte_cnt == '0) w_len_nxt = w_sel_data[DW-1:2];
          if (r_byte_cnt != CNT_MAX) w_byte_cnt_nxt = r_byte_cnt + CW'(1);
          // Byte beyond header plus len payload bytes is an overrun.
          if (r_byte_cnt == ({1'b0, r_len} + CW'(1))) w_len_err_nxt = 1'b1;
        end else if (!w_sel_valid && !router_busy) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!router_busy) begin
          w_grant_nxt    = '0;
          w_byte_cnt_nxt = '0;
          w_rr_ptr_nxt   = IW'((int'(r_gidx) + 1) % int'(NUM_SRC));
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_gidx     <= '0;
      r_grant    <= '0;
      r_byte_cnt <= '0;
      r_len      <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_gidx     <= w_gidx_nxt;
      r_grant    <= w_grant_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_len      <= w_len_nxt;
      r_len_err  <= w_len_err_nxt;
    end
  end

  assign src_grant = r_grant;
  assign len_err   = r_len_err;

endmodule

// File: tb/tb_router_src_arbiter.sv
// Directed bench for router_src_arbiter: reset, single packet, round robin, stalls, overrun, busy idle.
module tb_router_src_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  src_pkt_valid;
  logic [31:0] src_data;
  logic        router_busy;
  logic [3:0]  src_busy;
  logic [3:0]  src_grant;
  logic        pkt_valid;
  logic [7:0]  data_in;
  logic        len_err;

  router_src_arbiter #(.NUM_SRC(4), .DW(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .src_pkt_valid(src_pkt_valid),
    .src_data     (src_data),
    .router_busy  (router_busy),
    .src_busy     (src_busy),
    .src_grant    (src_grant),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-source byte stream: {valid, byte}; a valid=0 entry is the parity cycle.
  logic [8:0] srcq [4][$];
  logic [7:0] log_q [$];
  int         gnt_log [$];
  logic [3:0] last_grant;
  int         err_cnt, err_at, pv_cycles, low_run, min_gap;
  bit         seen_pv;
  int         busy_trig = -1;
  int         busy_rem = 0;
  logic       rb_base = 1'b0;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() > 0) begin
        src_pkt_valid[i]     = srcq[i][0][8];
        src_data[i*8 +: 8]   = srcq[i][0][7:0];
      end else begin
        src_pkt_valid[i]     = 1'b0;
        src_data[i*8 +: 8]   = 8'h00;
      end
    end
  endtask

  task automatic clear_mon();
    log_q.delete();
    gnt_log.delete();
    last_grant = 4'h0;
    err_cnt = 0; err_at = -1; pv_cycles = 0; low_run = 0; min_gap = 1000; seen_pv = 0;
  endtask

  // Observe the current cycle at negedge, then advance one clock and drive new inputs.
  task automatic step();
    bit pop [4];
    @(negedge clk);
    for (int i = 0; i < 4; i++) pop[i] = (srcq[i].size() > 0) && !src_busy[i];
    if (len_err) begin err_cnt++; err_at = log_q.size(); end
    if (pkt_valid && !router_busy) log_q.push_back(data_in);
    if (pkt_valid) begin
      pv_cycles++;
      if (seen_pv && low_run > 0 && low_run < min_gap) min_gap = low_run;
      seen_pv = 1; low_run = 0;
    end else begin
      low_run++;
    end
    if (src_grant != 4'h0 && last_grant == 4'h0)
      for (int i = 0; i < 4; i++) if (src_grant[i]) gnt_log.push_back(i);
    last_grant = src_grant;
    if (busy_trig >= 0 && log_q.size() == busy_trig) begin busy_rem = 2; busy_trig = -1; end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (pop[i]) void'(srcq[i].pop_front());
    if (busy_rem > 0) begin router_busy = 1'b1; busy_rem--; end
    else router_busy = rb_base;
    drive();
  endtask

  task automatic load_pkt(input int s, input logic [7:0] hdr, input int n,
                          input logic [7:0] first, input logic [7:0] inc);
    logic [7:0] par;
    logic [7:0] b;
    par = hdr;
    srcq[s].push_back({1'b1, hdr});
    for (int j = 0; j < n; j++) begin
      b = first + 8'(int'(inc) * j);
      srcq[s].push_back({1'b1, b});
      par ^= b;
    end
    srcq[s].push_back({1'b0, par});
  endtask

  task automatic run_idle(input int maxc);
    int c;
    bit busy_any;
    c = 0;
    busy_any = 1;
    while (busy_any && c < maxc) begin
      step();
      c++;
      busy_any = (src_grant != 4'h0);
      for (int i = 0; i < 4; i++) if (srcq[i].size() > 0) busy_any = 1;
    end
    checks++;
    if (busy_any) begin
      errors++;
      $display("FAIL run_idle timeout: still active after %0d cycles, required idle", c);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    rb_base = 1'b0; router_busy = 1'b0; busy_trig = -1; busy_rem = 0;
    drive();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    clear_mon();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    router_busy = 1'b0;
    drive();
    #12;
    checks++;
    if ({src_busy, src_grant, pkt_valid, data_in, len_err} !== {4'hF, 4'h0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: busy=%h grant=%h pv=%b data=%h err=%b, required F 0 0 00 0",
               src_busy, src_grant, pkt_valid, data_in, len_err);
    end
    do_reset();
    load_pkt(0, 8'h0C, 3, 8'h71, 8'h01);
    drive();
    step();
    step();
    #1;
    checks++;
    if ({pkt_valid, src_grant} !== {1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL pre_reset_xfer: pv=%b grant=%b, required 1 0001", pkt_valid, src_grant);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({src_busy, src_grant, pkt_valid, data_in} !== {4'hF, 4'h0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL async_reset_mid_xfer: busy=%h grant=%h pv=%b data=%h, required F 0 0 00",
               src_busy, src_grant, pkt_valid, data_in);
    end
    do_reset();
  endtask

  task automatic test_single_packet();
    logic [7:0] pay [3];
    pay = '{8'h11, 8'h22, 8'h33};
    clear_mon();
    load_pkt(2, 8'h0D, 3, 8'h11, 8'h11);
    drive();
    #1;
    checks++;
    if (src_grant !== 4'h0) begin
      errors++;
      $display("FAIL grant_before_edge: grant=%b, required 0000", src_grant);
    end
    step(); #1;
    checks++;
    if ({src_grant, pkt_valid, data_in} !== {4'b0100, 1'b1, 8'h0D}) begin
      errors++;
      $display("FAIL header_cycle: grant=%b pv=%b data=%h, required 0100 1 0D",
               src_grant, pkt_valid, data_in);
    end
    for (int j = 0; j < 3; j++) begin
      step(); #1;
      checks++;
      if ({pkt_valid, data_in} !== {1'b1, pay[j]}) begin
        errors++;
        $display("FAIL payload_%0d: pv=%b data=%h, required 1 %h", j, pkt_valid, data_in, pay[j]);
      end
    end
    step(); #1;
    checks++;
    if ({src_grant, pkt_valid, data_in} !== {4'b0100, 1'b0, 8'h0D}) begin
      errors++;
      $display("FAIL parity_cycle: grant=%b pv=%b data=%h, required 0100 0 0D",
               src_grant, pkt_valid, data_in);
    end
    step(); #1;
    checks++;
    if ({src_busy, src_grant, pkt_valid, data_in} !== {4'hF, 4'b0100, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL drain_cycle: busy=%h grant=%b pv=%b data=%h, required F 0100 0 00",
               src_busy, src_grant, pkt_valid, data_in);
    end
    step(); #1;
    checks++;
    if (src_grant !== 4'h0) begin
      errors++;
      $display("FAIL back_to_idle: grant=%b, required 0000", src_grant);
    end
    checks++;
    if (pv_cycles !== 4 || err_cnt !== 0) begin
      errors++;
      $display("FAIL single_pv_err: pv_cycles=%0d len_err=%0d, required 4 0", pv_cycles, err_cnt);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [5];
    logic [7:0] exp_b [15];
    bit ok;
    exp_g = '{0, 1, 2, 3, 0};
    exp_b = '{8'h08, 8'h01, 8'h02, 8'h09, 8'h11, 8'h12, 8'h0A, 8'h21, 8'h22,
              8'h0B, 8'h31, 8'h32, 8'h08, 8'h41, 8'h42};
    do_reset();
    load_pkt(0, 8'h08, 2, 8'h01, 8'h01);
    load_pkt(1, 8'h09, 2, 8'h11, 8'h01);
    load_pkt(2, 8'h0A, 2, 8'h21, 8'h01);
    load_pkt(3, 8'h0B, 2, 8'h31, 8'h01);
    load_pkt(0, 8'h08, 2, 8'h41, 8'h01);
    drive();
    run_idle(200);
    ok = (gnt_log.size() == 5);
    if (ok) for (int i = 0; i < 5; i++) if (gnt_log[i] != exp_g[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_order: got %p, required 0 1 2 3 0", gnt_log);
    end
    ok = (log_q.size() == 15);
    if (ok) for (int i = 0; i < 15; i++) if (log_q[i] !== exp_b[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_bytes: got %0d bytes %p, required 15 in grant order", log_q.size(), log_q);
    end
    checks++;
    if (min_gap < 2 || err_cnt != 0) begin
      errors++;
      $display("FAIL rr_gap: min gap=%0d len_err=%0d, required >=2 and 0", min_gap, err_cnt);
    end
  endtask

  task automatic test_busy_stall();
    logic [7:0] exp_b [4];
    bit ok;
    exp_b = '{8'h0D, 8'h51, 8'h52, 8'h53};
    clear_mon();
    load_pkt(1, 8'h0D, 3, 8'h51, 8'h01);
    busy_trig = 3;
    drive();
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({src_busy, src_grant, pkt_valid, data_in} !== {4'hF, 4'b0010, 1'b1, 8'h53}) begin
        errors++;
        $display("FAIL stall_%0d: busy=%h grant=%b pv=%b data=%h, required F 0010 1 53",
                 k, src_busy, src_grant, pkt_valid, data_in);
      end
      step();
    end
    run_idle(50);
    ok = (log_q.size() == 4);
    if (ok) for (int i = 0; i < 4; i++) if (log_q[i] !== exp_b[i]) ok = 0;
    checks++;
    if (!ok || err_cnt != 0) begin
      errors++;
      $display("FAIL stall_bytes: got %p len_err=%0d, required 0D 51 52 53 and 0", log_q, err_cnt);
    end
  endtask

  task automatic test_len_err();
    logic [7:0] exp_b [5];
    bit ok;
    exp_b = '{8'h08, 8'h61, 8'h62, 8'h63, 8'h64};
    clear_mon();
    load_pkt(0, 8'h08, 4, 8'h61, 8'h01);
    drive();
    run_idle(50);
    checks++;
    if (err_cnt != 1 || err_at != 4) begin
      errors++;
      $display("FAIL len_err_pulse: count=%0d after_bytes=%0d, required 1 after 4", err_cnt, err_at);
    end
    ok = (log_q.size() == 5);
    if (ok) for (int i = 0; i < 5; i++) if (log_q[i] !== exp_b[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL len_err_fwd: got %p, required 08 61 62 63 64", log_q);
    end
  endtask

  task automatic test_busy_idle();
    clear_mon();
    rb_base = 1'b1;
    router_busy = 1'b1;
    load_pkt(3, 8'h07, 1, 8'h81, 8'h01);
    drive();
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      checks++;
      if ({src_grant, src_busy} !== {4'h0, 4'hF}) begin
        errors++;
        $display("FAIL busy_idle_%0d: grant=%b busy=%h, required 0000 F", k, src_grant, src_busy);
      end
    end
    rb_base = 1'b0;
    router_busy = 1'b0;
    #1;
    checks++;
    if (src_grant !== 4'h0) begin
      errors++;
      $display("FAIL busy_drop_no_edge: grant=%b, required 0000", src_grant);
    end
    step(); #1;
    checks++;
    if ({src_grant, pkt_valid, data_in} !== {4'b1000, 1'b1, 8'h07}) begin
      errors++;
      $display("FAIL busy_drop_grant: grant=%b pv=%b data=%h, required 1000 1 07",
               src_grant, pkt_valid, data_in);
    end
    run_idle(50);
    checks++;
    if (log_q.size() != 2 || log_q[0] !== 8'h07 || log_q[1] !== 8'h81) begin
      errors++;
      $display("FAIL busy_idle_bytes: got %p, required 07 81", log_q);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) srcq[i].delete();
    clear_mon();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_busy_stall();
    test_len_err();
    test_busy_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
